dither_sequencer: RTL and testbench

- Programmable sequencer for the SPGD perturbation datapath.
- Drives the paired DAC outputs through a repeating +/0/- dither cycle. Phase lengths, settle time and repeat count come from GPIO register writes.
- Emits an ADC sample-window strobe and phase tag so the gradient accumulator knows when and what to integrate.
- Sits between the PS GPIO block and the DAC/ADC front end on ADC_CLK.

---
 rtl/dither_pkg.sv | 85 ++++++++
 rtl/dither_sequencer_phase_counter.sv | 82 ++++++++
 rtl/dither_sequencer.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_dither_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dither_pkg.sv
// -----------------------------------------------------------------------------
// dither_pkg
// Shared definitions for the SPGD dither sequencer:
//   - GPIO command opcodes
//   - DAC code constants for the plus / zero / minus perturbation phases
//   - sequencer state encoding and the phase-tag encoding seen by the accumulator
//   - power-on defaults of the programmable timing registers
//   - small decode helpers mapping a state onto its DAC codes, tag and busy flag
// -----------------------------------------------------------------------------
package dither_pkg;

    // Command opcodes carried in GP_IN[30:28]
    localparam logic [2:0] OP_T_PLUS   = 3'b001;
    localparam logic [2:0] OP_T_ZERO   = 3'b010;
    localparam logic [2:0] OP_T_MINUS  = 3'b011;
    localparam logic [2:0] OP_T_SETTLE = 3'b100;
    localparam logic [2:0] OP_N_REP    = 3'b101;

    // Two's-complement full-scale codes: +max and -max, plus mid-scale zero
    localparam logic [13:0] DAC_CODE_POS  = 14'h1FFF;
    localparam logic [13:0] DAC_CODE_NEG  = 14'h2000;
    localparam logic [13:0] DAC_CODE_ZERO = 14'h0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLUS  = 3'd1,
        ST_ZERO  = 3'd2,
        ST_MINUS = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Phase tag reported to the gradient accumulator
    localparam logic [1:0] TAG_IDLE  = 2'b00;
    localparam logic [1:0] TAG_PLUS  = 2'b01;
    localparam logic [1:0] TAG_ZERO  = 2'b10;
    localparam logic [1:0] TAG_MINUS = 2'b11;

    // Register defaults after reset
    localparam logic [23:0] DEF_T_PHASE  = 24'd1000;
    localparam logic [23:0] DEF_T_SETTLE = 24'd100;
    localparam logic [15:0] DEF_N_REP    = 16'd0;

    // Channel A drives +max in PLUS and -max in MINUS
    function automatic logic [13:0] dac_a_code(input state_t st);
        logic [13:0] code;
        case (st)
            ST_PLUS:  code = DAC_CODE_POS;
            ST_MINUS: code = DAC_CODE_NEG;
            default:  code = DAC_CODE_ZERO;
        endcase
        return code;
    endfunction

    // Channel B is the mirror of channel A
    function automatic logic [13:0] dac_b_code(input state_t st);
        logic [13:0] code;
        case (st)
            ST_PLUS:  code = DAC_CODE_NEG;
            ST_MINUS: code = DAC_CODE_POS;
            default:  code = DAC_CODE_ZERO;
        endcase
        return code;
    endfunction

    function automatic logic [1:0] phase_tag(input state_t st);
        logic [1:0] tag;
        case (st)
            ST_PLUS:  tag = TAG_PLUS;
            ST_ZERO:  tag = TAG_ZERO;
            ST_MINUS: tag = TAG_MINUS;
            default:  tag = TAG_IDLE;
        endcase
        return tag;
    endfunction

    function automatic logic is_busy(input state_t st);
        logic busy;
        case (st)
            ST_PLUS, ST_ZERO, ST_MINUS: busy = 1'b1;
            default:                    busy = 1'b0;
        endcase
        return busy;
    endfunction

endpackage

// File: rtl/dither_sequencer_phase_counter.sv
// -----------------------------------------------------------------------------
// phase_counter
// Down-counter timing one dither phase. Loaded with the phase length at each
// phase boundary; both flags are registered so they line up with the state
// register of the sequencer that loads the counter on the same edge.
//   clk, rst_n   : clock, asynchronous active-low reset
//   srst         : synchronous clear (idle / done), highest priority
//   load         : start a new phase of length len (0 treated as 1)
//   enable       : advance one cycle inside the current phase
//   len, settle  : phase length and settle time
//   tc           : current cycle is the last cycle of the phase
//   past_settle  : cycles already elapsed in this phase >= settle
// -----------------------------------------------------------------------------
module phase_counter #(
    parameter int CNT_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 srst,
    input  logic                 load,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] len,
    input  logic [CNT_WIDTH-1:0] settle,
    output logic                 tc,
    output logic                 past_settle
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_TWO  = CNT_WIDTH'(2);

    logic [CNT_WIDTH-1:0] remain_r;
    logic [CNT_WIDTH-1:0] elapsed_r;
    logic                 tc_r;
    logic                 past_r;
    logic [CNT_WIDTH-1:0] load_len_s;
    logic [CNT_WIDTH:0]   elapsed_inc_s;

    // Clamp a zero length to one cycle; widen the elapsed increment so it never wraps
    always_comb begin
        if (len == CNT_ZERO) begin
            load_len_s = CNT_ONE;
        end else begin
            load_len_s = len;
        end
        elapsed_inc_s = {1'b0, elapsed_r} + {{CNT_WIDTH{1'b0}}, 1'b1};
    end

    // Remaining/elapsed counters and the registered flags for the upcoming cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain_r  <= CNT_ZERO;
            elapsed_r <= CNT_ZERO;
            tc_r      <= 1'b0;
            past_r    <= 1'b0;
        end else if (srst) begin
            remain_r  <= CNT_ZERO;
            elapsed_r <= CNT_ZERO;
            tc_r      <= 1'b0;
            past_r    <= 1'b0;
        end else if (load) begin
            remain_r  <= load_len_s;
            elapsed_r <= CNT_ZERO;
            tc_r      <= (load_len_s == CNT_ONE);
            past_r    <= (settle == CNT_ZERO);
        end else if (enable && (remain_r > CNT_ONE)) begin
            remain_r  <= remain_r - CNT_ONE;
            elapsed_r <= elapsed_inc_s[CNT_WIDTH-1:0];
            tc_r      <= (remain_r == CNT_TWO);
            past_r    <= (elapsed_inc_s >= {1'b0, settle});
        end else begin
            remain_r  <= remain_r;
            elapsed_r <= elapsed_r;
            tc_r      <= tc_r;
            past_r    <= past_r;
        end
    end

    assign tc          = tc_r;
    assign past_settle = past_r;

endmodule

// File: rtl/dither_sequencer.sv
// -----------------------------------------------------------------------------
// dither_sequencer
// Drives the paired DACs through a repeating plus / zero / minus dither cycle
// for SPGD perturbation and tells the gradient accumulator when to sample.
//   ADC_CLK    : sole clock
//   ADC_RST_N  : asynchronous active-low reset
//   GP_IN      : command word [31] RUN, [30:28] opcode, [27] write toggle,
//                [23:0] payload
//   GP_OUT     : status [0] busy, [1] done, [2] werr, [5:4] phase tag,
//                [31:16] completed cycles
//   DAC_A_OUT  : channel A code (two's complement)
//   DAC_B_OUT  : channel B code (two's complement)
//   SAMPLE_EN  : ADC sample window open
//   PHASE_TAG  : 00 idle, 01 plus, 10 zero, 11 minus
// -----------------------------------------------------------------------------
module dither_sequencer
    import dither_pkg::*;
#(
    parameter int GPIO_WIDTH = 32,
    parameter int DAC_WIDTH  = 14,
    parameter int CNT_WIDTH  = 24,
    parameter int REP_WIDTH  = 16
) (
    input  logic                  ADC_CLK,
    input  logic                  ADC_RST_N,
    input  logic [GPIO_WIDTH-1:0] GP_IN,
    output logic [GPIO_WIDTH-1:0] GP_OUT,
    output logic [DAC_WIDTH-1:0]  DAC_A_OUT,
    output logic [DAC_WIDTH-1:0]  DAC_B_OUT,
    output logic                  SAMPLE_EN,
    output logic [1:0]            PHASE_TAG
);

    logic [GPIO_WIDTH-1:0] gp_meta_r;
    logic [GPIO_WIDTH-1:0] gp_sync_r;

    logic                  run_s;
    logic [2:0]            op_s;
    logic                  tog_s;
    logic [CNT_WIDTH-1:0]  payload_s;
    logic                  unused_gp_s;

    logic                  tog_r;
    logic                  werr_r;
    logic [CNT_WIDTH-1:0]  t_plus_r;
    logic [CNT_WIDTH-1:0]  t_zero_r;
    logic [CNT_WIDTH-1:0]  t_minus_r;
    logic [CNT_WIDTH-1:0]  t_settle_r;
    logic [REP_WIDTH-1:0]  n_rep_r;

    logic                  wr_edge_s;
    logic                  op_valid_s;
    logic [CNT_WIDTH-1:0]  t_plus_nxt_s;
    logic [CNT_WIDTH-1:0]  t_zero_nxt_s;
    logic [CNT_WIDTH-1:0]  t_minus_nxt_s;
    logic [CNT_WIDTH-1:0]  t_settle_nxt_s;
    logic [REP_WIDTH-1:0]  n_rep_nxt_s;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [REP_WIDTH-1:0]  completed_r;
    logic [REP_WIDTH-1:0]  completed_nxt_s;
    logic [REP_WIDTH-1:0]  completed_inc_s;
    logic                  last_rep_s;
    logic [DAC_WIDTH-1:0]  dac_a_r;
    logic [DAC_WIDTH-1:0]  dac_b_r;
    logic [1:0]            tag_r;
    logic                  busy_r;
    logic                  done_r;

    logic                  cnt_clear_s;
    logic                  cnt_load_s;
    logic                  cnt_en_s;
    logic [CNT_WIDTH-1:0]  cnt_len_s;
    logic                  cnt_tc_s;
    logic                  cnt_past_settle_s;

    logic [GPIO_WIDTH-1:0] status_s;

    // Two-flop synchroniser for the whole GPIO command word
    always_ff @(posedge ADC_CLK or negedge ADC_RST_N) begin
        if (!ADC_RST_N) begin
            gp_meta_r <= {GPIO_WIDTH{1'b0}};
            gp_sync_r <= {GPIO_WIDTH{1'b0}};
        end else begin
            gp_meta_r <= GP_IN;
            gp_sync_r <= gp_meta_r;
        end
    end

    assign run_s       = gp_sync_r[31];
    assign op_s        = gp_sync_r[30:28];
    assign tog_s       = gp_sync_r[27];
    assign payload_s   = gp_sync_r[CNT_WIDTH-1:0];
    assign unused_gp_s = ^gp_sync_r[26:24];

    // Write decode; the *_nxt values let a write that coincides with RUN feed this run
    always_comb begin
        wr_edge_s      = tog_s ^ tog_r;
        op_valid_s     = 1'b0;
        t_plus_nxt_s   = t_plus_r;
        t_zero_nxt_s   = t_zero_r;
        t_minus_nxt_s  = t_minus_r;
        t_settle_nxt_s = t_settle_r;
        n_rep_nxt_s    = n_rep_r;
        if (wr_edge_s && !busy_r) begin
            case (op_s)
                OP_T_PLUS: begin
                    t_plus_nxt_s = payload_s;
                    op_valid_s   = 1'b1;
                end
                OP_T_ZERO: begin
                    t_zero_nxt_s = payload_s;
                    op_valid_s   = 1'b1;
                end
                OP_T_MINUS: begin
                    t_minus_nxt_s = payload_s;
                    op_valid_s    = 1'b1;
                end
                OP_T_SETTLE: begin
                    t_settle_nxt_s = payload_s;
                    op_valid_s     = 1'b1;
                end
                OP_N_REP: begin
                    n_rep_nxt_s = payload_s[REP_WIDTH-1:0];
                    op_valid_s  = 1'b1;
                end
                default: begin
                    op_valid_s = 1'b0;
                end
            endcase
        end else begin
            op_valid_s = 1'b0;
        end
    end

    // Configuration registers, write toggle capture and write-error flag
    always_ff @(posedge ADC_CLK or negedge ADC_RST_N) begin
        if (!ADC_RST_N) begin
            tog_r      <= 1'b0;
            werr_r     <= 1'b0;
            t_plus_r   <= DEF_T_PHASE;
            t_zero_r   <= DEF_T_PHASE;
            t_minus_r  <= DEF_T_PHASE;
            t_settle_r <= DEF_T_SETTLE;
            n_rep_r    <= DEF_N_REP;
        end else begin
            // Capturing every cycle equals capturing only on a difference
            tog_r      <= tog_s;
            t_plus_r   <= t_plus_nxt_s;
            t_zero_r   <= t_zero_nxt_s;
            t_minus_r  <= t_minus_nxt_s;
            t_settle_r <= t_settle_nxt_s;
            n_rep_r    <= n_rep_nxt_s;
            if (wr_edge_s && busy_r) begin
                werr_r <= 1'b1;
            end else if (op_valid_s) begin
                werr_r <= 1'b0;
            end else begin
                werr_r <= werr_r;
            end
        end
    end

    // Next-state, completed-cycle count and phase counter control
    always_comb begin
        completed_inc_s = completed_r + REP_WIDTH'(1);
        last_rep_s      = (n_rep_r != {REP_WIDTH{1'b0}}) && (completed_inc_s == n_rep_r);
        state_nxt_s     = state_r;
        completed_nxt_s = completed_r;
        cnt_clear_s     = 1'b0;
        cnt_load_s      = 1'b0;
        cnt_en_s        = 1'b0;
        cnt_len_s       = t_plus_nxt_s;
        if (!run_s) begin
            state_nxt_s = ST_IDLE;
            cnt_clear_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s     = ST_PLUS;
                    completed_nxt_s = {REP_WIDTH{1'b0}};
                    cnt_load_s      = 1'b1;
                    cnt_len_s       = t_plus_nxt_s;
                end
                ST_PLUS: begin
                    if (cnt_tc_s) begin
                        state_nxt_s = ST_ZERO;
                        cnt_load_s  = 1'b1;
                        cnt_len_s   = t_zero_r;
                    end else begin
                        cnt_en_s = 1'b1;
                    end
                end
                ST_ZERO: begin
                    if (cnt_tc_s) begin
                        state_nxt_s = ST_MINUS;
                        cnt_load_s  = 1'b1;
                        cnt_len_s   = t_minus_r;
                    end else begin
                        cnt_en_s = 1'b1;
                    end
                end
                ST_MINUS: begin
                    if (cnt_tc_s) begin
                        completed_nxt_s = completed_inc_s;
                        if (last_rep_s) begin
                            state_nxt_s = ST_DONE;
                            cnt_clear_s = 1'b1;
                        end else begin
                            state_nxt_s = ST_PLUS;
                            cnt_load_s  = 1'b1;
                            cnt_len_s   = t_plus_r;
                        end
                    end else begin
                        cnt_en_s = 1'b1;
                    end
                end
                ST_DONE: begin
                    cnt_clear_s = 1'b1;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_clear_s = 1'b1;
                end
            endcase
        end
    end

    // Sequencer FSM; outputs are registered from the next state so they align with it
    always_ff @(posedge ADC_CLK or negedge ADC_RST_N) begin
        if (!ADC_RST_N) begin
            state_r     <= ST_IDLE;
            completed_r <= {REP_WIDTH{1'b0}};
            dac_a_r     <= {DAC_WIDTH{1'b0}};
            dac_b_r     <= {DAC_WIDTH{1'b0}};
            tag_r       <= TAG_IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            completed_r <= completed_nxt_s;
            dac_a_r     <= dac_a_code(state_nxt_s);
            dac_b_r     <= dac_b_code(state_nxt_s);
            tag_r       <= phase_tag(state_nxt_s);
            busy_r      <= is_busy(state_nxt_s);
            done_r      <= (state_nxt_s == ST_DONE);
        end
    end

    phase_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_phase_counter (
        .clk         (ADC_CLK),
        .rst_n       (ADC_RST_N),
        .srst        (cnt_clear_s),
        .load        (cnt_load_s),
        .enable      (cnt_en_s),
        .len         (cnt_len_s),
        .settle      (t_settle_nxt_s),
        .tc          (cnt_tc_s),
        .past_settle (cnt_past_settle_s)
    );

    // Status word assembled purely from registers
    always_comb begin
        status_s        = {GPIO_WIDTH{1'b0}};
        status_s[0]     = busy_r;
        status_s[1]     = done_r;
        status_s[2]     = werr_r;
        status_s[5:4]   = tag_r;
        status_s[31:16] = completed_r[15:0];
    end

    assign GP_OUT    = status_s;
    assign DAC_A_OUT = dac_a_r;
    assign DAC_B_OUT = dac_b_r;
    assign SAMPLE_EN = cnt_past_settle_s;
    assign PHASE_TAG = tag_r;

endmodule

// File: tb/tb_dither_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dither_sequencer
// Directed self-checking bench for dither_sequencer. Inputs change and outputs
// are sampled on the falling edge of ADC_CLK.
// -----------------------------------------------------------------------------
module tb_dither_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] gp_in;
    logic [31:0] gp_out;
    logic [13:0] dac_a;
    logic [13:0] dac_b;
    logic        sample_en;
    logic [1:0]  phase_tag;

    int   total  = 0;
    int   passed = 0;
    logic tog_v  = 1'b0;

    dither_sequencer dut (
        .ADC_CLK   (clk),
        .ADC_RST_N (rst_n),
        .GP_IN     (gp_in),
        .GP_OUT    (gp_out),
        .DAC_A_OUT (dac_a),
        .DAC_B_OUT (dac_b),
        .SAMPLE_EN (sample_en),
        .PHASE_TAG (phase_tag)
    );

    always #5 clk = ~clk;

    // Drive a command word; toggling bit 27 requests a register write
    task automatic drive_word(input logic run, input logic [2:0] op,
                              input logic [23:0] payload, input logic do_tog);
        if (do_tog) tog_v = ~tog_v;
        gp_in = {run, op, tog_v, 3'b000, payload};
    endtask

    task automatic write_reg(input logic [2:0] op, input logic [23:0] payload);
        @(negedge clk);
        drive_word(gp_in[31], op, payload, 1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic set_run(input logic run);
        @(negedge clk);
        gp_in[31] = run;
    endtask

    task automatic wait_tag(input logic [1:0] tag, input int bound, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < bound && !ok) begin
            if (phase_tag === tag) ok = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
    endtask

    // Walk one phase starting at its first cycle; returns on the first cycle after it
    task automatic measure(input logic [1:0] tag, output int len, output int hi,
                           output logic [13:0] a, output logic [13:0] b, output bit shape_ok);
        len = 0; hi = 0; shape_ok = 1'b1;
        a = dac_a; b = dac_b;
        while (phase_tag === tag && len < 5000) begin
            if (sample_en === 1'b1) hi++;
            else if (hi != 0) shape_ok = 1'b0;
            if (dac_a !== a || dac_b !== b) shape_ok = 1'b0;
            len++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        gp_in = 32'h0;
        tog_v = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (dac_a !== 14'h0) $display("FAIL reset_dac_a: got %h want 0000", dac_a); else passed++;
        total++; if (dac_b !== 14'h0) $display("FAIL reset_dac_b: got %h want 0000", dac_b); else passed++;
        total++; if (sample_en !== 1'b0) $display("FAIL reset_sample: got %b want 0", sample_en); else passed++;
        total++; if (phase_tag !== 2'b00) $display("FAIL reset_tag: got %b want 00", phase_tag); else passed++;
        total++; if (gp_out !== 32'h0) $display("FAIL reset_gp_out: got %h want 00000000", gp_out); else passed++;
    endtask

    task automatic test_defaults();
        bit ok, shp; int len, hi; logic [13:0] a, b;
        set_run(1'b1);
        wait_tag(2'b01, 10, ok);
        total++; if (!ok) $display("FAIL def_start: PLUS not reached, tag %b", phase_tag); else passed++;
        measure(2'b01, len, hi, a, b, shp);
        total++; if (len !== 1000 || hi !== 900) $display("FAIL def_plus_len: got len %0d hi %0d want 1000 900", len, hi); else passed++;
        total++; if (a !== 14'h1FFF || b !== 14'h2000 || !shp) $display("FAIL def_plus_codes: got %h %h shape %0d want 1fff 2000 1", a, b, shp); else passed++;
        measure(2'b10, len, hi, a, b, shp);
        total++; if (len !== 1000 || hi !== 900) $display("FAIL def_zero_len: got len %0d hi %0d want 1000 900", len, hi); else passed++;
        total++; if (a !== 14'h0 || b !== 14'h0 || !shp) $display("FAIL def_zero_codes: got %h %h shape %0d want 0000 0000 1", a, b, shp); else passed++;
        measure(2'b11, len, hi, a, b, shp);
        total++; if (len !== 1000 || hi !== 900) $display("FAIL def_minus_len: got len %0d hi %0d want 1000 900", len, hi); else passed++;
        total++; if (a !== 14'h2000 || b !== 14'h1FFF || !shp) $display("FAIL def_minus_codes: got %h %h shape %0d want 2000 1fff 1", a, b, shp); else passed++;
        total++; if (phase_tag !== 2'b01 || gp_out[31:16] !== 16'd1) $display("FAIL def_repeat: got tag %b count %0d want 01 1", phase_tag, gp_out[31:16]); else passed++;
        set_run(1'b0);
        wait_tag(2'b00, 10, ok);
        total++; if (!ok || gp_out[0] !== 1'b0) $display("FAIL def_stop: got tag %b busy %b want 00 0", phase_tag, gp_out[0]); else passed++;
    endtask

    task automatic test_program();
        bit ok, shp; int len, hi; logic [13:0] a, b;
        write_reg(3'b001, 24'd5);
        write_reg(3'b010, 24'd3);
        write_reg(3'b011, 24'd4);
        write_reg(3'b100, 24'd2);
        write_reg(3'b101, 24'd2);
        set_run(1'b1);
        wait_tag(2'b01, 10, ok);
        total++; if (!ok) $display("FAIL prog_start: PLUS not reached, tag %b", phase_tag); else passed++;
        for (int r = 0; r < 2; r++) begin
            measure(2'b01, len, hi, a, b, shp);
            total++; if (len !== 5 || hi !== 3 || !shp) $display("FAIL prog_plus: got len %0d hi %0d shape %0d want 5 3 1", len, hi, shp); else passed++;
            measure(2'b10, len, hi, a, b, shp);
            total++; if (len !== 3 || hi !== 1 || !shp) $display("FAIL prog_zero: got len %0d hi %0d shape %0d want 3 1 1", len, hi, shp); else passed++;
            measure(2'b11, len, hi, a, b, shp);
            total++; if (len !== 4 || hi !== 2 || !shp) $display("FAIL prog_minus: got len %0d hi %0d shape %0d want 4 2 1", len, hi, shp); else passed++;
        end
        total++; if (gp_out[1:0] !== 2'b10 || gp_out[31:16] !== 16'd2) $display("FAIL prog_done: got done/busy %b count %0d want 10 2", gp_out[1:0], gp_out[31:16]); else passed++;
        total++; if (dac_a !== 14'h0 || dac_b !== 14'h0 || sample_en !== 1'b0 || phase_tag !== 2'b00) $display("FAIL prog_done_outs: got %h %h %b %b want 0000 0000 0 00", dac_a, dac_b, sample_en, phase_tag); else passed++;
        repeat (5) @(negedge clk);
        total++; if (gp_out[1] !== 1'b1 || phase_tag !== 2'b00) $display("FAIL prog_done_hold: got done %b tag %b want 1 00", gp_out[1], phase_tag); else passed++;
        set_run(1'b0);
        repeat (4) @(negedge clk);
        total++; if (gp_out[1] !== 1'b0 || gp_out[31:16] !== 16'd2) $display("FAIL prog_idle: got done %b count %0d want 0 2", gp_out[1], gp_out[31:16]); else passed++;
    endtask

    task automatic test_run_drop();
        bit ok; int lat;
        write_reg(3'b010, 24'd8);
        set_run(1'b1);
        wait_tag(2'b01, 10, ok);
        wait_tag(2'b10, 20, ok);
        wait_tag(2'b11, 20, ok);
        wait_tag(2'b01, 20, ok);
        wait_tag(2'b10, 20, ok);
        total++; if (!ok) $display("FAIL drop_reach_zero: got tag %b want 10", phase_tag); else passed++;
        set_run(1'b0);
        lat = 0;
        while (phase_tag !== 2'b00 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        total++; if (lat !== 3) $display("FAIL drop_latency: got %0d cycles want 3", lat); else passed++;
        total++; if (dac_a !== 14'h0 || dac_b !== 14'h0 || sample_en !== 1'b0 || gp_out[0] !== 1'b0) $display("FAIL drop_outs: got %h %h %b busy %b want 0000 0000 0 0", dac_a, dac_b, sample_en, gp_out[0]); else passed++;
        total++; if (gp_out[31:16] !== 16'd1) $display("FAIL drop_count_held: got %0d want 1", gp_out[31:16]); else passed++;
        set_run(1'b1);
        wait_tag(2'b01, 10, ok);
        total++; if (!ok || gp_out[31:16] !== 16'd0 || dac_a !== 14'h1FFF) $display("FAIL drop_restart: got tag %b count %0d dac_a %h want 01 0 1fff", phase_tag, gp_out[31:16], dac_a); else passed++;
        set_run(1'b0);
        wait_tag(2'b00, 10, ok);
    endtask

    task automatic test_busy_write();
        bit ok, shp; int len, hi; logic [13:0] a, b;
        write_reg(3'b101, 24'd0);
        set_run(1'b1);
        wait_tag(2'b01, 10, ok);
        drive_word(1'b1, 3'b001, 24'd7, 1'b1);
        repeat (3) @(negedge clk);
        total++; if (gp_out[2] !== 1'b1) $display("FAIL busy_werr_set: got %b want 1", gp_out[2]); else passed++;
        wait_tag(2'b11, 30, ok);
        wait_tag(2'b01, 30, ok);
        measure(2'b01, len, hi, a, b, shp);
        total++; if (len !== 5) $display("FAIL busy_t_plus_kept: got len %0d want 5", len); else passed++;
        set_run(1'b0);
        wait_tag(2'b00, 10, ok);
        write_reg(3'b001, 24'd5);
        total++; if (gp_out[2] !== 1'b0) $display("FAIL busy_werr_clear: got %b want 0", gp_out[2]); else passed++;
    endtask

    task automatic test_run_with_write();
        bit ok, shp; int len, hi; logic [13:0] a, b;
        write_reg(3'b100, 24'd10);
        @(negedge clk);
        drive_word(1'b1, 3'b001, 24'd0, 1'b1);
        wait_tag(2'b01, 10, ok);
        measure(2'b01, len, hi, a, b, shp);
        total++; if (len !== 1 || hi !== 0 || a !== 14'h1FFF) $display("FAIL zl_plus: got len %0d hi %0d a %h want 1 0 1fff", len, hi, a); else passed++;
        measure(2'b10, len, hi, a, b, shp);
        total++; if (len !== 8 || hi !== 0) $display("FAIL zl_zero: got len %0d hi %0d want 8 0", len, hi); else passed++;
        measure(2'b11, len, hi, a, b, shp);
        total++; if (len !== 4 || hi !== 0) $display("FAIL zl_minus: got len %0d hi %0d want 4 0", len, hi); else passed++;
        total++; if (phase_tag !== 2'b01 || gp_out[2] !== 1'b0) $display("FAIL zl_continue: got tag %b werr %b want 01 0", phase_tag, gp_out[2]); else passed++;
    endtask

    task automatic test_async_reset();
        bit ok, shp; int len, hi; logic [13:0] a, b;
        wait_tag(2'b11, 30, ok);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        gp_in = 32'h0;
        tog_v = 1'b0;
        #1;
        total++; if (dac_a !== 14'h0 || dac_b !== 14'h0) $display("FAIL arst_dac: got %h %h want 0000 0000", dac_a, dac_b); else passed++;
        total++; if (sample_en !== 1'b0 || phase_tag !== 2'b00 || gp_out !== 32'h0) $display("FAIL arst_status: got %b %b %h want 0 00 00000000", sample_en, phase_tag, gp_out); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        set_run(1'b1);
        wait_tag(2'b01, 10, ok);
        measure(2'b01, len, hi, a, b, shp);
        total++; if (len !== 1000 || hi !== 900) $display("FAIL arst_defaults: got len %0d hi %0d want 1000 900", len, hi); else passed++;
        set_run(1'b0);
        wait_tag(2'b00, 10, ok);
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_program();
        test_run_drop();
        test_busy_write();
        test_run_with_write();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
